// File: rtl/rvc_fetch_aligner.sv
// Fetch-word to instruction aligner: halfword queue, 32-bit realignment and RV32C expansion.
// Optional issue statistics (stat_total, stat_compressed) are built when RVC_STATS_EN is defined.
module rvc_fetch_aligner #(
    parameter int          FETCH_WIDTH = 32,
    parameter int          QUEUE_HW    = 6,
    parameter logic [31:0] RESET_PC    = 32'h0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic [31:0]            flush_pc,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [FETCH_WIDTH-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_instr,
    output logic [31:0]            out_pc,
    output logic                   out_compressed,
    output logic                   out_illegal
`ifdef RVC_STATS_EN
    ,
    output logic [31:0]            stat_total,
    output logic [31:0]            stat_compressed
`endif
);

    localparam int FW_HW = FETCH_WIDTH / 16;
    localparam int PTR_W = $clog2(QUEUE_HW);
    localparam int CNT_W = $clog2(QUEUE_HW + 1);

    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input logic [PTR_W-1:0] n);
        logic [PTR_W:0] s;
        s = {1'b0, p} + {1'b0, n};
        if (s >= (PTR_W+1)'(QUEUE_HW))
            s = s - (PTR_W+1)'(QUEUE_HW);
        return s[PTR_W-1:0];
    endfunction

    function automatic logic [31:0] j_type(input logic [20:1] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
    endfunction

    // Returns {illegal, expanded instruction} for a 16-bit encoding.
    function automatic logic [32:0] rvc_expand(input logic [15:0] c);
        logic [31:0] ins;
        logic        ill;
        logic [4:0]  rd, rs2, rdp, rs1p;
        logic [11:0] imm6s;
        logic [20:1] jimm;
        logic [12:1] bimm;
        ins   = 32'h0;
        ill   = 1'b0;
        rd    = c[11:7];
        rs2   = c[6:2];
        rdp   = {2'b01, c[4:2]};
        rs1p  = {2'b01, c[9:7]};
        imm6s = {{6{c[12]}}, c[12], c[6:2]};
        jimm  = {{10{c[12]}}, c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3]};
        bimm  = {{5{c[12]}}, c[6:5], c[2], c[11:10], c[4:3]};
        case (c[1:0])
            2'b00: case (c[15:13])
                3'b000: begin
                    ins = {2'b00, c[10:7], c[12:11], c[5], c[6], 2'b00, 5'd2, 3'b000, rdp, 7'h13};
                    ill = (c[12:5] == 8'h0);
                end
                3'b010: ins = {5'b0, c[5], c[12:10], c[6], 2'b00, rs1p, 3'b010, rdp, 7'h03};
                3'b110: ins = {5'b0, c[5], c[12], rdp, rs1p, 3'b010, c[11:10], c[6], 2'b00, 7'h23};
                default: ill = 1'b1;
            endcase
            2'b01: case (c[15:13])
                3'b000: ins = {imm6s, rd, 3'b000, rd, 7'h13};
                3'b001: ins = j_type(jimm, 5'd1);
                3'b010: ins = {imm6s, 5'd0, 3'b000, rd, 7'h13};
                3'b011: begin
                    ill = ({c[12], c[6:2]} == 6'h0);
                    if (rd == 5'd2)
                        ins = {{3{c[12]}}, c[4:3], c[5], c[2], c[6], 4'b0000, 5'd2, 3'b000, 5'd2, 7'h13};
                    else
                        ins = {{15{c[12]}}, c[6:2], rd, 7'h37};
                end
                3'b100: case (c[11:10])
                    2'b00: begin ins = {7'b0000000, c[6:2], rs1p, 3'b101, rs1p, 7'h13}; ill = c[12]; end
                    2'b01: begin ins = {7'b0100000, c[6:2], rs1p, 3'b101, rs1p, 7'h13}; ill = c[12]; end
                    2'b10: ins = {imm6s, rs1p, 3'b111, rs1p, 7'h13};
                    default: begin
                        ill = c[12];
                        case (c[6:5])
                            2'b00:   ins = {7'b0100000, rdp, rs1p, 3'b000, rs1p, 7'h33};
                            2'b01:   ins = {7'b0000000, rdp, rs1p, 3'b100, rs1p, 7'h33};
                            2'b10:   ins = {7'b0000000, rdp, rs1p, 3'b110, rs1p, 7'h33};
                            default: ins = {7'b0000000, rdp, rs1p, 3'b111, rs1p, 7'h33};
                        endcase
                    end
                endcase
                3'b101: ins = j_type(jimm, 5'd0);
                3'b110: ins = {bimm[12], bimm[10:5], 5'd0, rs1p, 3'b000, bimm[4:1], bimm[11], 7'h63};
                default: ins = {bimm[12], bimm[10:5], 5'd0, rs1p, 3'b001, bimm[4:1], bimm[11], 7'h63};
            endcase
            2'b10: case (c[15:13])
                3'b000: begin ins = {7'b0000000, c[6:2], rd, 3'b001, rd, 7'h13}; ill = c[12]; end
                3'b010: begin
                    ins = {4'b0, c[3:2], c[12], c[6:4], 2'b00, 5'd2, 3'b010, rd, 7'h03};
                    ill = (rd == 5'd0);
                end
                3'b100: begin
                    if (!c[12]) begin
                        if (rs2 == 5'd0) begin
                            ins = {12'h0, rd, 3'b000, 5'd0, 7'h67};
                            ill = (rd == 5'd0);
                        end else
                            ins = {7'b0, rs2, 5'd0, 3'b000, rd, 7'h33};
                    end else if (rs2 == 5'd0 && rd == 5'd0)
                        ins = 32'h0010_0073;
                    else if (rs2 == 5'd0)
                        ins = {12'h0, rd, 3'b000, 5'd1, 7'h67};
                    else
                        ins = {7'b0, rs2, rd, 3'b000, rd, 7'h33};
                end
                3'b110: ins = {4'b0, c[8:7], c[12], c[6:2], 5'd2, 3'b010, c[11:9], 2'b00, 7'h23};
                default: ill = 1'b1;
            endcase
            default: ins = 32'h0;
        endcase
        if (c == 16'h0)
            ill = 1'b1;
        return {ill, ins};
    endfunction

    logic [15:0]      r_q [QUEUE_HW];
    logic [PTR_W-1:0] r_head, r_tail;
    logic [CNT_W-1:0] r_count;
    logic [31:0]      r_pc;
    logic             r_drop;

    logic [15:0]      w_hw [FW_HW];
    logic [15:0]      w_h0, w_h1;
    logic             w_is32, w_push, w_pop;
    logic [CNT_W-1:0] w_push_n, w_pop_n;
    logic [32:0]      w_exp;

    // With drop_first set, the upper halfwords slide down one slot and the top one is unused.
    genvar g;
    for (g = 0; g < FW_HW; g++) begin : g_src
        if (g + 1 < FW_HW) begin : g_mid
            assign w_hw[g] = r_drop ? in_data[16*(g+1) +: 16] : in_data[16*g +: 16];
        end else begin : g_last
            assign w_hw[g] = r_drop ? 16'h0 : in_data[16*g +: 16];
        end
    end

    assign w_h0     = r_q[r_head];
    assign w_h1     = r_q[ptr_add(r_head, PTR_W'(1))];
    assign w_is32   = (w_h0[1:0] == 2'b11);
    assign w_exp    = rvc_expand(w_h0);
    assign w_push_n = r_drop ? CNT_W'(FW_HW - 1) : CNT_W'(FW_HW);
    assign w_pop_n  = w_is32 ? CNT_W'(2) : CNT_W'(1);

    assign in_ready       = !flush && (r_count <= CNT_W'(QUEUE_HW - FW_HW));
    assign out_valid      = w_is32 ? (r_count >= CNT_W'(2)) : (r_count != '0);
    assign w_push         = in_valid && in_ready;
    assign w_pop          = out_valid && out_ready && !flush;
    assign out_pc         = r_pc;
    assign out_compressed = out_valid && !w_is32;
    assign out_illegal    = out_valid && !w_is32 && w_exp[32];
    assign out_instr      = !out_valid ? 32'h0 :
                            w_is32     ? {w_h1, w_h0} :
                            w_exp[32]  ? {16'h0, w_h0} : w_exp[31:0];

    always_ff @(posedge clk) begin
        for (int k = 0; k < FW_HW; k++)
            if (w_push && (CNT_W'(k) < w_push_n))
                r_q[ptr_add(r_tail, PTR_W'(k))] <= w_hw[k];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_pc    <= RESET_PC;
            r_drop  <= 1'b0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_pc    <= flush_pc & ~32'h1;
            r_drop  <= flush_pc[1];
        end else begin
            if (w_push) begin
                r_tail <= ptr_add(r_tail, PTR_W'(w_push_n));
                r_drop <= 1'b0;
            end
            if (w_pop) begin
                r_head <= ptr_add(r_head, PTR_W'(w_pop_n));
                r_pc   <= r_pc + (w_is32 ? 32'd4 : 32'd2);
            end
            r_count <= r_count + (w_push ? w_push_n : '0) - (w_pop ? w_pop_n : '0);
        end
    end

`ifdef RVC_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_total      <= 32'h0;
            stat_compressed <= 32'h0;
        end else if (w_pop) begin
            stat_total <= stat_total + 32'd1;
            if (!w_is32)
                stat_compressed <= stat_compressed + 32'd1;
        end
    end
`endif

endmodule
